// File: rtl/clock_disp_pkg.sv
// Shared constants, glyph codes and the shadow-time payload for the clock display.
package clock_disp_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned RGB_W        = 12;
    localparam int unsigned ROM_ADDR_W   = 11;
    localparam int unsigned ROM_DATA_W   = 8;
    localparam int unsigned FCNT_W       = 6;

    localparam int unsigned NUM_CELLS    = 9;
    localparam int unsigned FRAME_ROW    = 480;
    localparam int unsigned FRAME_LAST   = 59;
    localparam int unsigned BLINK_HALF   = 30;

    localparam logic [3:0] GLYPH_COLON   = 4'hA;
    localparam logic [3:0] GLYPH_STAT_A  = 4'hB;
    localparam logic [3:0] GLYPH_STAT_T  = 4'hC;
    localparam logic [2:0] ROM_PREFIX    = 3'b011;

    // Time digits and alarm flag as captured once per frame
    typedef struct packed {
        logic [3:0] hr_t;
        logic [3:0] hr_o;
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
        logic       alarm_mode;
    } time_shadow_t;

    // Non-decimal BCD nibbles are drawn as empty cells
    function automatic logic is_blank_digit(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/clock_frame_sync.sv
// Frame-event detector, per-frame shadow of the time digits and optional colon blink.
// Optional feature: CLOCK_COLON_BLINK_EN compiles in the frame counter and blink qualifier.
import clock_disp_pkg::*;

module clock_frame_sync (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   pixel_x,
    input  logic [COORD_W-1:0]   pixel_y,
    input  time_shadow_t         time_now,
    output time_shadow_t         shadow,
    output logic                 colon_hide_c
);

    logic frame_cond_c;
    logic frame_cond_d;
    logic frame_evt_c;

    assign frame_cond_c = (pixel_y == COORD_W'(FRAME_ROW)) && (pixel_x == '0);
    assign frame_evt_c  = frame_cond_c && !frame_cond_d;

    // Edge register and shadow capture on the frame event
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cond_d <= 1'b0;
            shadow       <= '0;
        end else begin
            frame_cond_d <= frame_cond_c;
            if (frame_evt_c) begin
                shadow <= time_now;
            end
        end
    end

`ifdef CLOCK_COLON_BLINK_EN
    logic [FCNT_W-1:0] frame_cnt;

    // Frame counter 0..59, one step per frame event
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_evt_c) begin
            if (frame_cnt == FCNT_W'(FRAME_LAST)) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

    assign colon_hide_c = (frame_cnt >= FCNT_W'(BLINK_HALF));
`else
    assign colon_hide_c = 1'b0;
`endif

endmodule

// File: rtl/clock_digit_renderer.sv
// Maps the scan position onto the HH:MM:SS+status glyph strip, addresses the glyph
// ROM and turns the returned row byte into a registered RGB pixel (2 clk latency).
// Optional feature: CLOCK_COLON_BLINK_EN blinks the colon cells at 1 Hz.
import clock_disp_pkg::*;

module clock_digit_renderer #(
    parameter int unsigned      X0         = 176,
    parameter int unsigned      Y0         = 208,
    parameter int unsigned      SCALE_LOG2 = 2,
    parameter logic [RGB_W-1:0] FG         = 12'hFFF,
    parameter logic [RGB_W-1:0] BG         = 12'h000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    video_on,
    input  logic [COORD_W-1:0]      pixel_x,
    input  logic [COORD_W-1:0]      pixel_y,
    input  logic [DIGIT_W-1:0]      hr_t,
    input  logic [DIGIT_W-1:0]      hr_o,
    input  logic [DIGIT_W-1:0]      min_t,
    input  logic [DIGIT_W-1:0]      min_o,
    input  logic [DIGIT_W-1:0]      sec_t,
    input  logic [DIGIT_W-1:0]      sec_o,
    input  logic                    alarm_mode,
    output logic [ROM_ADDR_W-1:0]   rom_addr,
    input  logic [ROM_DATA_W-1:0]   rom_data,
    output logic [RGB_W-1:0]        rgb
);

    localparam int unsigned STRIP_W    = (8 * NUM_CELLS) << SCALE_LOG2;
    localparam int unsigned STRIP_H    = 16 << SCALE_LOG2;
    localparam int unsigned CELL_SHIFT = 3 + SCALE_LOG2;

    time_shadow_t       time_now;
    time_shadow_t       shadow;
    logic               colon_hide_c;

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic               in_strip_c;
    logic [3:0]         cell_c;
    logic [2:0]         col_c;
    logic [3:0]         row_c;
    logic [3:0]         code_c;
    logic               blank_c;

    logic               video_on_d;
    logic               in_strip_d;
    logic [2:0]         col_d;
    logic               blank_d;

    assign time_now = '{hr_t: hr_t, hr_o: hr_o, min_t: min_t, min_o: min_o,
                        sec_t: sec_t, sec_o: sec_o, alarm_mode: alarm_mode};

    clock_frame_sync u_frame_sync (
        .clk          (clk),
        .reset        (reset),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .time_now     (time_now),
        .shadow       (shadow),
        .colon_hide_c (colon_hide_c)
    );

    // Strip-local coordinates; off-strip positions wrap to large values
    assign dx         = pixel_x - COORD_W'(X0);
    assign dy         = pixel_y - COORD_W'(Y0);
    assign in_strip_c = (32'(dx) < STRIP_W) && (32'(dy) < STRIP_H);
    assign cell_c     = 4'(dx >> CELL_SHIFT);
    assign col_c      = 3'(dx >> SCALE_LOG2);
    assign row_c      = 4'(dy >> SCALE_LOG2);

    // Cell mux: glyph code and blank qualifier per strip cell
    always_comb begin
        code_c  = '0;
        blank_c = 1'b0;
        case (cell_c)
            4'd0: begin code_c = shadow.hr_t;  blank_c = is_blank_digit(shadow.hr_t);  end
            4'd1: begin code_c = shadow.hr_o;  blank_c = is_blank_digit(shadow.hr_o);  end
            4'd3: begin code_c = shadow.min_t; blank_c = is_blank_digit(shadow.min_t); end
            4'd4: begin code_c = shadow.min_o; blank_c = is_blank_digit(shadow.min_o); end
            4'd6: begin code_c = shadow.sec_t; blank_c = is_blank_digit(shadow.sec_t); end
            4'd7: begin code_c = shadow.sec_o; blank_c = is_blank_digit(shadow.sec_o); end
            4'd2, 4'd5: begin
                code_c  = GLYPH_COLON;
                blank_c = colon_hide_c;
            end
            4'd8: code_c = shadow.alarm_mode ? GLYPH_STAT_A : GLYPH_STAT_T;
            default: blank_c = 1'b1;
        endcase
    end

    assign rom_addr = {ROM_PREFIX, code_c, row_c};

    // Align pixel qualifiers with the ROM's one-cycle read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            video_on_d <= 1'b0;
            in_strip_d <= 1'b0;
            col_d      <= '0;
            blank_d    <= 1'b0;
        end else begin
            video_on_d <= video_on;
            in_strip_d <= in_strip_c;
            col_d      <= col_c;
            blank_d    <= blank_c;
        end
    end

    // Output colour select
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb <= '0;
        end else if (video_on_d && in_strip_d && rom_data[3'd7 - col_d] && !blank_d) begin
            rgb <= FG;
        end else if (video_on_d) begin
            rgb <= BG;
        end else begin
            rgb <= '0;
        end
    end

endmodule

// File: doc/clock_digit_renderer.md
# clock_digit_renderer

Pixel-stage text generator for the VGA clock display. It maps the current scan position onto a 9-cell glyph strip, HH:MM:SS plus one status cell. It drives the address of the clock digit glyph ROM and consumes that ROM's row byte one cycle later to produce the 12-bit RGB pixel. It sits between the VGA sync generator and timekeeping counters upstream, and the RGB output register downstream.

## Interface
- `X0`, 176: left pixel column of the strip
- `Y0`, 208: top pixel row of the strip
- `SCALE_LOG2`, 2: glyph magnification is 2^SCALE_LOG2 (cell 32x64 at default)
- `FG`, 12'hFFF: foreground colour
- `BG`, 12'h000: background colour (also used outside the strip while video_on)
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-high
- `video_on`  in  1  from sync generator, aligned with pixel_x/pixel_y
- `pixel_x`  in  10  current column
- `pixel_y`  in  10  current row
- `hr_t`, `hr_o`, `min_t`, `min_o`, `sec_t`, `sec_o`  in  4 each  BCD time digits
- `alarm_mode`  in  1  status cell shows glyph 0xB when 1, glyph 0xC when 0
- `rom_addr`  out  11  glyph ROM address (combinational from pixel_x/pixel_y and shadow digits)
- `rom_data`  in  8  glyph row byte, valid one clk after rom_addr; MSB is leftmost pixel
- `rgb`  out  12  pixel colour, registered

## Operation
- Glyph addressing: rom_addr = {3'b011, code[3:0], row[3:0]}, i.e. 0x300 + code*16 + row. Codes 0-9 are digits, 0xA is colon, 0xB/0xC are status glyphs.
- Local coordinates: dx = pixel_x - X0, dy = pixel_y - Y0 (10-bit, unsigned wrap). in_strip = (dx < 72<<SCALE_LOG2) && (dy < 16<<SCALE_LOG2).
- cell = dx >> (3+SCALE_LOG2), range 0..8. col = (dx >> SCALE_LOG2)[2:0]. row = (dy >> SCALE_LOG2)[3:0].
- Cell order:
  - 0: hr_t
  - 1: hr_o
  - 2: colon
  - 3: min_t
  - 4: min_o
  - 5: colon
  - 6: sec_t
  - 7: sec_o
  - 8: status
- BCD digits > 9 render blank (pixel forced BG); rom_addr is still issued.
- Shadow registers:
  - Digits and alarm_mode are captured into shadow registers once per frame, on the first clk where pixel_y == 480 && pixel_x == 0 (rising edge of that condition; the edge is the frame event).
  - Rendering uses shadow values only, so no mid-frame tearing.
- Frame counter: 6 bits, increments per frame event, wraps 59 -> 0.
- Output select, from delayed signals:
  - rgb = FG when video_on_d && in_strip_d && rom_data[7-col_d] && !blank_d
  - else BG when video_on_d
  - else 12'h000

## Timing
- rom_addr is combinational, the same cycle as pixel_x/pixel_y. The ROM registers the address, so rom_data is valid at cycle +1.
- video_on, in_strip, col and blank are delayed one register stage to align with rom_data.
- rgb is registered at cycle +2. Total latency pixel_x -> rgb is 2 clk. The sync generator delays hsync/vsync by 2 clk to match.
- Reset values:
  - rgb 12'h000
  - all delay stages 0
  - shadow digits 0
  - shadow alarm_mode 0
  - frame counter 0
  - frame-event edge register 0
- Reset mid-frame: outputs are BG-free black for 2 clk, then the strip renders shadow zeros ("00:00:00", status 0xC) until the next frame event.
- A frame event in the same clk as a digit change captures the new digit value present on that clk.

## Configuration
- `CLOCK_COLON_BLINK_EN` defined:
  - Colon cells render normally for frame counter 0-29 and render blank for 30-59 (1 Hz at 60 fps).
  - The frame counter and blink qualifier are compiled in.
- Undefined: colons are always shown; the frame counter is omitted.

## Structure
- Shared package `clock_disp_pkg` holds:
  - glyph code constants (GLYPH_COLON=4'hA, GLYPH_STAT_A=4'hB, GLYPH_STAT_T=4'hC)
  - ROM base prefix 3'b011
  - strip cell count 9
  - frame-event row 480
- One natural sub-module, `clock_frame_sync`: frame-event edge detector, shadow register bank and optional blink counter. The top level keeps coordinate math, the cell mux and the alignment pipeline.

## Test plan
- Reset held 3 clk with video_on=1 -> rgb=000 throughout and 2 clk after release; shadow reads 0.
- Digits 12:34:56, frame event, then scan pixel (X0, Y0+2<<S) -> rom_addr=0x312. rgb FG at +2 clk when rom_data bit7=1, else BG.
- Cell 2 at row 4 -> rom_addr=0x3A4; alarm_mode=1 at cell 8 row 7 -> rom_addr=0x3B7.
- sec_o=4'hF -> cell 7 always BG, with any rom_data.
- Digit change mid-frame -> rendered value unchanged until the next pixel_y=480,x=0 event.
- With CLOCK_COLON_BLINK_EN, run 60 frame events -> colon FG in frames 0-29, BG in 30-59, counter wraps to 0.
